ifu_prefetch: RTL and testbench

- Parametrised successor to the core's instruction fetch unit.
- Owns the fetch PC and issues single-outstanding requests to instruction memory over a valid/ready handshake.
- Buffers returned instructions, each tagged with its PC, in a DEPTH-entry queue; decode drains the queue with a valid/ready handshake.
- Supports flush plus redirect (absolute, base+offset, reset vector). Sits between instruction cache and decode.

---
 rtl/ifu_pkg.sv | 16 +
 rtl/ifu_prefetch_if.sv | 42 ++++
 rtl/ifu_prefetch_fetch_queue.sv | 68 ++++++
 rtl/ifu_prefetch.sv | 114 +++++++++++
 tb/tb_ifu_prefetch.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ifu_pkg.sv
// Shared encodings for the instruction prefetch unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ifu_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } ifu_state_e;

    localparam logic [1:0] SEL_ABS = 2'b00;
    localparam logic [1:0] SEL_REL = 2'b01;
    localparam logic [1:0] SEL_RST = 2'b10;

endpackage

// File: rtl/ifu_prefetch_if.sv
// Bundle of redirect, memory request/response and decode-side signals of the prefetch unit.
// Latency: n/a (wiring only).
// Backpressure: mem_req_ready_in stalls requests, ins_ready_in stalls the queue head.
interface ifu_prefetch_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int QUEUE_DEPTH = 4
);
    localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

    logic                  redirect_valid_in;
    logic [1:0]            redirect_sel_in;
    logic [ADDR_WIDTH-1:0] pc_upd_addr_in;
    logic [ADDR_WIDTH-1:0] pc_offset_in;
    logic                  mem_req_valid_out;
    logic [ADDR_WIDTH-1:0] mem_req_addr_out;
    logic                  mem_req_ready_in;
    logic                  mem_resp_valid_in;
    logic [DATA_WIDTH-1:0] mem_resp_data_in;
    logic                  ins_valid_out;
    logic [DATA_WIDTH-1:0] ins_data_out;
    logic [ADDR_WIDTH-1:0] ins_pc_out;
    logic                  ins_ready_in;
    logic [CNT_W-1:0]      queue_count_out;

    modport master (
        input  redirect_valid_in, redirect_sel_in, pc_upd_addr_in, pc_offset_in,
        output mem_req_valid_out, mem_req_addr_out,
        input  mem_req_ready_in, mem_resp_valid_in, mem_resp_data_in,
        output ins_valid_out, ins_data_out, ins_pc_out, queue_count_out,
        input  ins_ready_in
    );

    modport slave (
        output redirect_valid_in, redirect_sel_in, pc_upd_addr_in, pc_offset_in,
        input  mem_req_valid_out, mem_req_addr_out,
        output mem_req_ready_in, mem_resp_valid_in, mem_resp_data_in,
        input  ins_valid_out, ins_data_out, ins_pc_out, queue_count_out,
        output ins_ready_in
    );

endinterface

// File: rtl/ifu_prefetch_fetch_queue.sv
// Synchronous FIFO holding {pc, instruction} entries; clear beats push and pop.
// Latency: pushed entry visible at head the cycle after the push.
// Backpressure: pop on empty is ignored; caller must never push when full.
module fetch_queue #(
    parameter int  WIDTH = 64,
    parameter int  DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head_dat
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != '0);
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count    = count_q;
    assign head_dat = mem_q[rd_ptr_q];

    no_push_when_full: assert property (@(posedge clk) disable iff (rst)
        !(push && !clear && count_q == CW'(DEPTH)));

endmodule

// File: rtl/ifu_prefetch.sv
// Fetch PC owner: single-outstanding instruction fetch into a PC-tagged prefetch queue.
// Latency: request the cycle after reset release; response enters queue the cycle after it arrives.
// Backpressure: requests stop while the queue is full; decode stalls via ins_ready_in.
module ifu_prefetch
    import ifu_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    INS_BYTES   = 4,
    parameter int                    QUEUE_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR  = '0
) (
    input  logic           ifu_clock_in,
    input  logic           ifu_reset_in,
    ifu_prefetch_if.master bus
);

    localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

    ifu_state_e                       state_q, state_d;
    logic [ADDR_WIDTH-1:0]            fpc_q, fpc_d;
    logic [ADDR_WIDTH-1:0]            req_addr_q, req_addr_d;
    logic [ADDR_WIDTH-1:0]            target;
    logic                             req_vld;
    logic                             push;
    logic                             pop;
    logic [CNT_W-1:0]                 count;
    logic [ADDR_WIDTH+DATA_WIDTH-1:0] head;

    always_comb begin
        case (bus.redirect_sel_in)
            SEL_REL: target = bus.pc_upd_addr_in + bus.pc_offset_in;
            SEL_RST: target = RESET_ADDR;
            SEL_ABS: target = bus.pc_upd_addr_in;
            default: target = bus.pc_upd_addr_in;
        endcase
    end

    assign req_vld = (state_q == FETCH) && (count < CNT_W'(QUEUE_DEPTH))
                     && !bus.redirect_valid_in && !ifu_reset_in;

    always_comb begin
        state_d    = state_q;
        fpc_d      = fpc_q;
        req_addr_d = req_addr_q;
        push       = 1'b0;
        case (state_q)
            FETCH: begin
                if (req_vld && bus.mem_req_ready_in) begin
                    req_addr_d = fpc_q;
                    fpc_d      = fpc_q + ADDR_WIDTH'(INS_BYTES);
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (bus.mem_resp_valid_in) begin
                    push    = 1'b1;
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                if (bus.mem_resp_valid_in) begin
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
        // A redirect never issues (req_vld is low), so only WAIT needs to remember the
        // in-flight response; DRAIN keeps its own resp->FETCH exit so it cannot deadlock.
        if (bus.redirect_valid_in) begin
            push  = 1'b0;
            fpc_d = target;
            if (state_q == WAIT && !bus.mem_resp_valid_in) begin
                state_d = DRAIN;
            end
        end
    end

    always_ff @(posedge ifu_clock_in) begin
        if (ifu_reset_in) begin
            state_q    <= FETCH;
            fpc_q      <= RESET_ADDR;
            req_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            fpc_q      <= fpc_d;
            req_addr_q <= req_addr_d;
        end
    end

    assign pop = bus.ins_valid_out && bus.ins_ready_in;

    fetch_queue #(
        .WIDTH(ADDR_WIDTH + DATA_WIDTH),
        .DEPTH(QUEUE_DEPTH)
    ) u_queue (
        .clk      (ifu_clock_in),
        .rst      (ifu_reset_in),
        .clear    (bus.redirect_valid_in),
        .push     (push),
        .push_dat ({req_addr_q, bus.mem_resp_data_in}),
        .pop      (pop),
        .count    (count),
        .head_dat (head)
    );

    assign bus.mem_req_valid_out = req_vld;
    assign bus.mem_req_addr_out  = fpc_q;
    assign bus.ins_valid_out     = (count != '0);
    assign bus.ins_pc_out        = head[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
    assign bus.ins_data_out      = head[DATA_WIDTH-1:0];
    assign bus.queue_count_out   = count;

endmodule

// File: tb/tb_ifu_prefetch.sv
// Bench for ifu_prefetch: memory responder, request/instruction scoreboards, redirect vector table.
module tb_ifu_prefetch;
    import ifu_pkg::*;

    localparam int          AW    = 32;
    localparam int          DW    = 32;
    localparam int          QD    = 4;
    localparam logic [31:0] RST_A = 32'hFFFF_FFFC;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] dat;
    } ins_t;

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] base;
        logic [31:0] off;
        logic [31:0] tgt;
    } redir_vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ifu_prefetch_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .QUEUE_DEPTH(QD)) bus ();

    ifu_prefetch #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INS_BYTES(4),
        .QUEUE_DEPTH(QD), .RESET_ADDR(RST_A)
    ) dut (
        .ifu_clock_in(clk),
        .ifu_reset_in(rst),
        .bus         (bus)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_req [$];
    ins_t        exp_ins [$];
    redir_vec_t  vecs [5];
    int          lat = 1;
    bit          pending = 0;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = '0;
    bit          acc = 0;
    bit          prev_hold = 0;
    logic [31:0] prev_addr = '0;
    bit          forbid_en = 0;
    logic [31:0] forbid_pc = '0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock: observe handshakes mid-cycle, clock, then drive the memory response.
    task automatic step();
        logic [31:0] e;
        ins_t        ei;
        #1;
        acc = 0;
        if (prev_hold && !bus.redirect_valid_in && !rst) begin
            chk("req_hold_vld", 32'(bus.mem_req_valid_out), 32'd1);
            chk("req_hold_addr", bus.mem_req_addr_out, prev_addr);
        end
        if (forbid_en && bus.ins_valid_out) begin
            n_cmp++;
            if (bus.ins_pc_out == forbid_pc) begin
                n_bad++;
                $display("FAIL stale_entry: head pc %h should have been flushed", bus.ins_pc_out);
            end
        end
        if (bus.mem_req_valid_out && bus.mem_req_ready_in) begin
            acc = 1;
            if (exp_req.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL req_addr: unexpected request %h", bus.mem_req_addr_out);
            end else begin
                e = exp_req.pop_front();
                chk("req_addr", bus.mem_req_addr_out, e);
            end
            pending   = 1;
            pend_cnt  = lat;
            pend_addr = bus.mem_req_addr_out;
        end
        if (bus.ins_valid_out && bus.ins_ready_in) begin
            if (exp_ins.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL ins_pop: unexpected pop pc %h", bus.ins_pc_out);
            end else begin
                ei = exp_ins.pop_front();
                chk("ins_pc", bus.ins_pc_out, ei.pc);
                chk("ins_data", bus.ins_data_out, ei.dat);
            end
        end
        prev_hold = bus.mem_req_valid_out && !bus.mem_req_ready_in;
        prev_addr = bus.mem_req_addr_out;
        @(posedge clk);
        #1;
        bus.mem_resp_valid_in = 1'b0;
        bus.mem_resp_data_in  = '0;
        if (pending) begin
            if (pend_cnt <= 1) begin
                bus.mem_resp_valid_in = 1'b1;
                bus.mem_resp_data_in  = word_of(pend_addr);
                pending = 0;
            end else begin
                pend_cnt--;
            end
        end
    endtask

    task automatic wait_acc(input string name);
        int n = 0;
        do begin
            step();
            n++;
        end while (!acc && n < 12);
        if (!acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no request accepted within 12 cycles, got none, expected one", name);
        end
    endtask

    task automatic redirect(input logic [1:0] sel, input logic [31:0] base, input logic [31:0] off);
        bus.redirect_valid_in = 1'b1;
        bus.redirect_sel_in   = sel;
        bus.pc_upd_addr_in    = base;
        bus.pc_offset_in      = off;
        step();
        bus.redirect_valid_in = 1'b0;
    endtask

    initial begin
        vecs[0] = '{SEL_ABS, 32'h0000_0340, 32'h0000_0000, 32'h0000_0340};
        vecs[1] = '{SEL_REL, 32'h0000_0200, 32'hFFFF_FFF0, 32'h0000_01F0};
        vecs[2] = '{SEL_RST, 32'h0000_1234, 32'h0000_0008, RST_A};
        vecs[3] = '{2'b11,   32'h0000_07C0, 32'h0000_0004, 32'h0000_07C0};
        vecs[4] = '{SEL_REL, 32'hFFFF_FFF8, 32'h0000_0010, 32'h0000_0008};

        bus.redirect_valid_in = 1'b0;
        bus.redirect_sel_in   = 2'b00;
        bus.pc_upd_addr_in    = '0;
        bus.pc_offset_in      = '0;
        bus.mem_req_ready_in  = 1'b1;
        bus.mem_resp_valid_in = 1'b0;
        bus.mem_resp_data_in  = '0;
        bus.ins_ready_in      = 1'b0;

        // Reset state
        repeat (3) step();
        chk("rst_req_vld", 32'(bus.mem_req_valid_out), 32'd0);
        chk("rst_ins_vld", 32'(bus.ins_valid_out), 32'd0);
        chk("rst_count", 32'(bus.queue_count_out), 32'd0);
        chk("rst_ins_pc", bus.ins_pc_out, 32'd0);
        chk("rst_ins_data", bus.ins_data_out, 32'd0);

        // Fill the queue from the reset vector; PC wraps past zero
        rst = 1'b0;
        for (int i = 0; i < 4; i++) exp_req.push_back(RST_A + 32'(4 * i));
        repeat (14) step();
        chk("fill_count", 32'(bus.queue_count_out), 32'd4);
        chk("fill_head_pc", bus.ins_pc_out, RST_A);
        chk("fill_head_data", bus.ins_data_out, word_of(RST_A));
        chk("fill_req_vld", 32'(bus.mem_req_valid_out), 32'd0);
        chk("fill_req_left", 32'(exp_req.size()), 32'd0);

        // Single pop frees one slot, exactly one more fetch follows
        exp_ins.push_back('{RST_A, word_of(RST_A)});
        exp_req.push_back(RST_A + 32'd16);
        bus.ins_ready_in = 1'b1;
        step();
        bus.ins_ready_in = 1'b0;
        chk("pop_count", 32'(bus.queue_count_out), 32'd3);
        repeat (8) step();
        chk("refill_count", 32'(bus.queue_count_out), 32'd4);
        chk("refill_head_pc", bus.ins_pc_out, RST_A + 32'd4);

        // Redirect while WAIT, response two cycles later must be dropped
        lat = 2;
        exp_ins.push_back('{RST_A + 32'd4, word_of(RST_A + 32'd4)});
        exp_req.push_back(RST_A + 32'd20);
        bus.ins_ready_in = 1'b1;
        step();
        bus.ins_ready_in = 1'b0;
        wait_acc("wait_redir_acc");
        for (int i = 0; i < 4; i++) exp_req.push_back(32'h100 + 32'(4 * i));
        redirect(SEL_ABS, 32'h100, 32'h0);
        chk("wait_redir_count", 32'(bus.queue_count_out), 32'd0);
        chk("wait_redir_vld", 32'(bus.ins_valid_out), 32'd0);
        forbid_en = 1;
        forbid_pc = RST_A + 32'd20;
        repeat (24) step();
        forbid_en = 0;
        chk("drain_count", 32'(bus.queue_count_out), 32'd4);
        chk("drain_head_pc", bus.ins_pc_out, 32'h100);
        chk("drain_req_left", 32'(exp_req.size()), 32'd0);

        // Redirect target table
        lat = 1;
        foreach (vecs[i]) begin
            bus.mem_req_ready_in = 1'b1;
            exp_req.push_back(vecs[i].tgt);
            redirect(vecs[i].sel, vecs[i].base, vecs[i].off);
            wait_acc("vec_acc");
            bus.mem_req_ready_in = 1'b0;
            repeat (3) step();
            chk("vec_count", 32'(bus.queue_count_out), 32'd1);
            chk("vec_head_pc", bus.ins_pc_out, vecs[i].tgt);
            chk("vec_head_data", bus.ins_data_out, word_of(vecs[i].tgt));
            chk("vec_next_vld", 32'(bus.mem_req_valid_out), 32'd1);
            chk("vec_next_addr", bus.mem_req_addr_out, vecs[i].tgt + 32'd4);
        end

        // Redirect in the same cycle as the response in WAIT
        bus.mem_req_ready_in = 1'b1;
        exp_req.push_back(32'h0000_000C);
        wait_acc("resp_redir_acc");
        exp_req.push_back(32'h400);
        redirect(SEL_ABS, 32'h400, 32'h0);
        chk("resp_redir_count", 32'(bus.queue_count_out), 32'd0);
        chk("resp_redir_vld", 32'(bus.ins_valid_out), 32'd0);
        forbid_en = 1;
        forbid_pc = 32'h0000_000C;
        wait_acc("resp_redir_next");
        bus.mem_req_ready_in = 1'b0;
        repeat (3) step();
        chk("resp_redir_count2", 32'(bus.queue_count_out), 32'd1);
        chk("resp_redir_pc", bus.ins_pc_out, 32'h400);

        // Redirect in the same cycle as push and pop
        bus.mem_req_ready_in = 1'b1;
        exp_req.push_back(32'h404);
        wait_acc("pp_redir_acc");
        exp_ins.push_back('{32'h400, word_of(32'h400)});
        exp_req.push_back(32'h500);
        bus.ins_ready_in = 1'b1;
        redirect(SEL_ABS, 32'h500, 32'h0);
        bus.ins_ready_in = 1'b0;
        chk("pp_redir_count", 32'(bus.queue_count_out), 32'd0);
        chk("pp_redir_vld", 32'(bus.ins_valid_out), 32'd0);
        forbid_pc = 32'h404;
        wait_acc("pp_redir_next");
        bus.mem_req_ready_in = 1'b0;
        repeat (3) step();
        forbid_en = 0;
        chk("pp_redir_count2", 32'(bus.queue_count_out), 32'd1);
        chk("pp_redir_pc", bus.ins_pc_out, 32'h500);

        chk("end_req_left", 32'(exp_req.size()), 32'd0);
        chk("end_ins_left", 32'(exp_ins.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
